// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: freezes fetch while an external loader writes instruction memory, then redirects fetch to BOOT_PC
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   ld_start                     enter load mode (sampled in RUN only)
//   ld_valid/ld_data/ld_last     loader word stream; ld_ready accepts it
//   hazard_stall -> stall_f      fetch stall (forced high while loading)
//   redirect, redirect_pc        fetch PC override to BOOT_PC
//   flush_d                      flush of the fetch/decode register
//   imem_we/imem_waddr/imem_wdata instruction-memory write port
//   word_count, overflow         words written / sticky dropped-word flag of the last load
//   load_done, busy              completion pulse / high outside RUN
module imem_load_ctrl #(
    parameter int          ADDR_WIDTH = 5,
    parameter logic [31:0] BOOT_PC    = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_start,
    input  logic                  ld_valid,
    input  logic [31:0]           ld_data,
    input  logic                  ld_last,
    output logic                  ld_ready,
    input  logic                  hazard_stall,
    output logic                  stall_f,
    output logic                  redirect,
    output logic [31:0]           redirect_pc,
    output logic                  flush_d,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_waddr,
    output logic [31:0]           imem_wdata,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  overflow,
    output logic                  load_done,
    output logic                  busy
);
    typedef enum logic [1:0] {REDIRECT, RUN, LOAD} state_t;
    state_t              state, state_nx;
    logic [ADDR_WIDTH:0] wc_nx;
    logic                ovf_nx, done_nx, hs, full;
    assign redirect_pc = BOOT_PC;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= REDIRECT;
            word_count <= '0;
            overflow   <= 1'b0;
            load_done  <= 1'b0;
        end else begin
            state      <= state_nx;
            word_count <= wc_nx;
            overflow   <= ovf_nx;
            load_done  <= done_nx;
        end
    end
    always_comb begin
        state_nx   = state;
        wc_nx      = word_count;
        ovf_nx     = overflow;
        done_nx    = 1'b0;
        hs         = (state == LOAD) && ld_valid;
        // MSB of word_count set means every memory word has been written
        full       = word_count[ADDR_WIDTH];
        redirect   = state == REDIRECT;
        flush_d    = state == REDIRECT;
        busy       = state != RUN;
        ld_ready   = state == LOAD;
        stall_f    = (state == LOAD) || ((state == RUN) && hazard_stall);
        imem_we    = hs && !full;
        imem_waddr = word_count[ADDR_WIDTH-1:0];
        imem_wdata = ld_data;
        case (state)
            REDIRECT: state_nx = RUN;
            RUN: if (ld_start) begin
                state_nx = LOAD;
                wc_nx    = '0;
                ovf_nx   = 1'b0;
            end
            LOAD: if (hs) begin
                if (full) ovf_nx = 1'b1;
                else wc_nx = word_count + 1'b1;
                if (ld_last) begin
                    state_nx = REDIRECT;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = REDIRECT;
        endcase
    end
endmodule

// File: doc/imem_load_ctrl.md
# imem_load_ctrl

Sequencing controller for the fetch stage and its instruction memory. It lets an external loader, such as a debug or UART bridge, write a program into instruction memory word by word while fetch is frozen. When loading ends, it redirects the fetch PC to the boot vector and flushes decode. It sits beside the hazard unit and owns the fetch stall, PC-redirect and instruction-memory write inputs.

## Interface
- ADDR_WIDTH, 5, word-address bits of instruction memory; depth = 2^ADDR_WIDTH words
- BOOT_PC, 32'h0000_0000, PC loaded on every redirect
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ld_start  in  1  request to enter load mode; sampled only in RUN
- ld_valid  in  1  loader word valid
- ld_data  in  32  loader instruction word
- ld_last  in  1  qualifies ld_valid: this is the final word
- ld_ready  out  1  controller accepts a loader word
- hazard_stall  in  1  stall request from the hazard unit
- stall_f  out  1  to fetch StallF
- redirect  out  1  to fetch PCSrc override
- redirect_pc  out  32  to fetch PC target; constant BOOT_PC
- flush_d  out  1  flushes the fetch/decode register
- imem_we  out  1  instruction-memory write enable
- imem_waddr  out  ADDR_WIDTH  word address of the write
- imem_wdata  out  32  write data
- word_count  out  ADDR_WIDTH+1  words written in the current or most recent load
- overflow  out  1  sticky flag: words were dropped because memory was full
- load_done  out  1  one-cycle pulse when a load completes
- busy  out  1  high in LOAD and REDIRECT

## Operation
- States: REDIRECT, RUN, LOAD. The reset state is REDIRECT.
- REDIRECT
  - Lasts exactly one cycle, then moves to RUN.
  - Outputs: redirect=1, flush_d=1, stall_f=0, ld_ready=0, busy=1.
- RUN
  - stall_f = hazard_stall; redirect=0; flush_d=0; ld_ready=0; busy=0.
  - ld_start=1 moves to LOAD next cycle. On that transition, word_count and overflow clear.
- LOAD
  - stall_f=1 regardless of hazard_stall; ld_ready=1; busy=1.
  - Handshake is ld_valid & ld_ready.
  - Each handshake with word_count < 2^ADDR_WIDTH:
    - Combinational outputs: imem_we=1, imem_waddr=word_count[ADDR_WIDTH-1:0], imem_wdata=ld_data.
    - Next cycle: word_count increments.
  - Each handshake with word_count == 2^ADDR_WIDTH:
    - Word is dropped, imem_we=0, overflow sets; word_count saturates.
  - Handshake with ld_last=1 (written or dropped): next state is REDIRECT, and load_done pulses during that REDIRECT cycle.
  - ld_start is ignored in LOAD and REDIRECT.
- imem_we is 0 outside LOAD. redirect_pc is always BOOT_PC.
- Reset values, held while rst_n=0:
  - state REDIRECT: redirect=1, flush_d=1, stall_f=0, busy=1.
  - ld_ready=0, imem_we=0, imem_waddr=0, imem_wdata=ld_data.
  - word_count=0, overflow=0, load_done=0.
- load_done does not pulse in the REDIRECT cycle that follows reset.

## Timing
- State, word_count, overflow and the load_done source are registered. All other outputs are combinational decodes of state and the handshake.
- ld_start to ld_ready: 1 cycle. The RUN cycle sampling ld_start still passes hazard_stall; stall_f=1 from the next edge.
- Write latency is 0: a word is written on the same edge it is accepted.
- Sustained throughput is 1 word per cycle.
- Last handshake to redirect: 1 cycle. Fetch loads BOOT_PC on the REDIRECT edge, and RUN begins the following cycle.
- ld_last on the first handshake is legal: a 1-word load.
- The loader may deassert ld_valid at any time in LOAD; the controller holds LOAD with no timeout.
- rst_n asserted mid-load aborts the load. Memory holds a partial image (contents unspecified beyond word_count). On release, the controller performs a normal post-reset REDIRECT with load_done=0.
- Release of rst_n is synchronized externally; the controller does not re-synchronize it.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release → redirect=1, flush_d=1 in the first cycle, RUN in the second; load_done=0; word_count=0.
- Normal load: ld_start, then 4 back-to-back words 0x11..0x44, last on the 4th → writes to addresses 0..3 on consecutive cycles, word_count=4, REDIRECT with load_done=1, then RUN.
- Gapped loader: ld_valid toggling 1,0,0,1 with hazard_stall=0 → stall_f stays 1 throughout LOAD, only 2 writes occur, addresses 0 and 1.
- Overflow with ADDR_WIDTH=2: send 6 words, last on the 6th → 4 writes; words 5–6 dropped; overflow=1; word_count=4; load still terminates.
- Hazard passthrough in RUN: toggle hazard_stall → stall_f follows it exactly; ld_start asserted during REDIRECT is ignored.
- Reset mid-load after 2 words → everything returns to reset values; the next load starts at address 0 with overflow cleared.
